// File: rtl/mdu_sched.sv
// -----------------------------------------------------------------------------
// mdu_sched -- multiply/divide sequencer and architectural HI/LO register pair
//
// The EX stage presents a 4-bit MDU code together with its forwarded operands.
// mult/multu/div/divu launch a multi-cycle operation: the result is computed
// into shadow registers at launch and committed to HI/LO when the latency
// counter expires. mthi/mtlo write HI/LO directly in a single cycle.
// While an operation is launching or in flight, any DE-stage instruction that
// touches the MDU or HI/LO is held by the stall output.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : code 7 = madd  ({HI,LO} += signed rs*rt)
//               code 8 = maddu ({HI,LO} += unsigned rs*rt)
//               both use MULT_CYCLES latency
//   undefined : codes 7..15 are no-ops, no accumulator adder is built
//
// Ports:
//   clk       in   1   core clock, rising edge
//   reset_n   in   1   asynchronous active-low reset
//   mductr    in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   rs_val    in  32   EX-stage forwarded rs operand
//   rt_val    in  32   EX-stage forwarded rt operand
//   d_md_use  in   1   DE-stage instruction uses the MDU or HI/LO
//   hi        out 32   architectural HI
//   lo        out 32   architectural LO
//   busy      out  1   operation in flight
//   start     out  1   an operation is launched this cycle (combinational)
//   stall     out  1   stall request to the hazard unit (combinational)
// -----------------------------------------------------------------------------
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  mductr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        start,
    output logic        stall
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] sh_hi_q, sh_hi_d;
    logic [31:0] sh_lo_q, sh_lo_d;

    logic        op_mul;
    logic        op_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] s_dvs;
    logic [31:0] u_dvs;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic [63:0] res;

    // ---------------------------------------------------------------- decode
    always_comb begin
        op_mul = (mductr == OP_MULT) || (mductr == OP_MULTU);
`ifdef MDU_MADD_EN
        op_mul = op_mul || (mductr == OP_MADD) || (mductr == OP_MADDU);
`endif
        op_div = (mductr == OP_DIV) || (mductr == OP_DIVU);
    end

    assign start = (state_q == IDLE) && (op_mul || op_div);
    assign busy  = (state_q == BUSY);
    assign stall = d_md_use && (start || busy);
    assign hi    = hi_q;
    assign lo    = lo_q;

    // ------------------------------------------------------------ arithmetic
    // Products are formed at full 64-bit width on explicitly extended operands
    // so the signed and unsigned forms differ only in the extension.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divisor is forced to 1 for divide-by-zero (result discarded anyway) and
    // for the 0x80000000 / -1 overflow case: dividing by 1 there yields
    // exactly the required LO=0x80000000, HI=0 without a special result path.
    assign div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign s_dvs   = ((rt_val == 32'd0) || div_ovf) ? 32'd1 : rt_val;
    assign u_dvs   = (rt_val == 32'd0) ? 32'd1 : rt_val;

    assign q_s = 32'($signed(rs_val) / $signed(s_dvs));
    assign r_s = 32'($signed(rs_val) % $signed(s_dvs));
    assign q_u = rs_val / u_dvs;
    assign r_u = rs_val % u_dvs;

    always_comb begin
        res = {hi_q, lo_q};
        case (mductr)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   if (rt_val != 32'd0) res = {r_s, q_s};
            OP_DIVU:  if (rt_val != 32'd0) res = {r_u, q_u};
`ifdef MDU_MADD_EN
            // Accumulate into the HI/LO value visible at launch.
            OP_MADD:  res = {hi_q, lo_q} + prod_s;
            OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
            default:  res = {hi_q, lo_q};
        endcase
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_hi_d = res[63:32];
                    sh_lo_d = res[31:0];
                    cnt_d   = op_div ? DIV_CNT : MULT_CNT;
                    state_d = BUSY;
                end else if (mductr == OP_MTHI) begin
                    hi_d = rs_val;
                end else if (mductr == OP_MTLO) begin
                    lo_d = rs_val;
                end
            end
            BUSY: begin
                // Any code arriving here is ignored; the stall keeps MDU
                // instructions out of EX while an operation is in flight.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = sh_hi_q;
                    lo_d    = sh_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

endmodule
